syscall_unit: RTL and testbench
===============================

Name: syscall_unit

Overview:
- Synthesizable syscall handler between the cpu's sys_signal/sysregs outputs and the memory array, trig table, vga block and text output.
- Decodes a 16-bit code in sysregs[15:0], plus arguments a = sysregs[31:16] and b = sysregs[47:32].
- Sequences memory and trig reads, vga command pulses and character output, and reports busy/halted back to system level.

Parameters:
- TRIG_DEPTH, 720, entries in the trig table; an index at or beyond it returns 0.
- STR_MAX, 256, maximum characters emitted by code 5 before forced termination.

Ports:
- clk  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- sys_signal  in  1  syscall request level from the cpu; accepted on its rising edge.
- sysregs  in  48  {b, a, code}, sampled in the cycle the rising edge is detected.
- busy  out  1  high from acceptance until the syscall completes.
- halted  out  1  sticky; set by code 0.
- load_signal  out  1  load_data is valid for the cpu.
- load_data  out  16  result of code 2, 9 or 10.
- mem_addr  out  16  memory address.
- mem_wdata  out  16  memory write data.
- mem_we  out  1  one-cycle memory write strobe.
- mem_re  out  1  read strobe; mem_rdata is valid exactly one cycle later.
- mem_rdata  in  16  memory read data.
- trig_addr  out  10  trig table index.
- trig_re  out  1  read strobe; trig_rdata is valid one cycle later.
- trig_rdata  in  16  trig read data.
- video_activate / video_clear / video_write  out  1 each  one-cycle pulses to vga.
- video_addr / video_data  out  16 each  held stable from the write pulse until the next code 8.
- out_valid  out  1  text output item valid.
- out_is_num  out  1  1 means out_data is a decimal number; 0 means an ASCII char in out_data[7:0].
- out_data  out  16  output item.
- out_ready  in  1  sink accepts the item when out_valid and out_ready are both high.

Behaviour:
- Reset (async on clear): every output is 0, the FSM enters IDLE and the edge detector's previous-level register is 0. Reset mid-operation aborts the syscall; no strobe may be emitted after clear rises.
- Acceptance: accept only in IDLE, only when halted=0, and only on sys_signal rising (previous level 0, current level 1). Capture code, a and b, set busy, and in the same edge clear load_signal unless the code is 2, 9 or 10. An edge arriving while busy is dropped.
- FSM states: IDLE, MRD, TRD, EMIT, SRD, SEMIT, DONE.
- Per code:
  - 0: halted<=1 and go to DONE.
  - 1: mem_we pulse with mem_addr=a and mem_wdata=b, then DONE.
  - 2: mem_re with mem_addr=a, go to MRD; next cycle load_data<=mem_rdata and load_signal<=1, then DONE. Latency is 2 cycles from acceptance to load_signal.
  - 3: EMIT with out_is_num=1 and out_data=a.
  - 4: EMIT with out_is_num=0 and out_data={8'h0,a[7:0]}.
  - 9/10: trig_re with trig_addr=2a (code 9) or 2a+1 (code 10), TRD, then load as for code 2. If the computed index is >= TRIG_DEPTH, load_data=0 and trig_re stays low. Index arithmetic is 17-bit so there is no wrap.
  - 5: loop SRD, then SEMIT. SRD reads mem[a+i]; a zero word ends the string and goes to DONE; otherwise SEMIT presents the char, waits for out_ready, then i++. The 16-bit address wraps 0xFFFF to 0x0000. The loop terminates after STR_MAX chars.
  - 6/7: one-cycle video_activate / video_clear pulse, then DONE.
  - 8: latch video_addr=a and video_data=b, pulse video_write one cycle, then DONE.
  - Any other code: no side effects, go to DONE.
- EMIT/SEMIT: hold out_valid and out_data stable until out_ready. If out_ready is already high, the item completes in that cycle.
- DONE: busy<=0 and return to IDLE after one cycle. This gives a minimum 2-cycle turnaround.
- Pulses never overlap. At most one of mem_we, mem_re, trig_re and the video pulses is high in any cycle.
- load_signal stays high until the next accepted syscall other than 2, 9 or 10.

Decomposition:
- Shared package holds:
  - Syscall code constants: SYS_HALT=0 through SYS_COS=10.
  - The FSM state enum.
  - The sysregs field slice constants.
- One natural sub-module: syscall_edge_detect (registered rising-edge detector, async clear).

Test Plan:
- Code 1 with a=0x0100, b=0xBEEF, then code 2 with a=0x0100 -> single mem_we at 0x0100; load_signal=1 with load_data=0xBEEF two cycles after the second edge.
- Code 5 with a=0x0200, mem="Hi\0", out_ready low for 3 cycles on 'i' -> out_data 0x48 then 0x69 held stable, no extra items, busy drops after the terminator read.
- Code 9 a=10 and code 10 a=10 -> trig_addr 20 and 21; a=400 -> load_data=0 with no trig_re.
- Code 8 a=5 b=0x41 followed by code 6 -> video_write one cycle with addr 5 / data 0x41 held; then a single video_activate pulse.
- sys_signal toggled while busy (code 5 stalled) -> second request ignored; code 0 -> halted=1 and later edges ignored.
- clear asserted during SEMIT -> all outputs 0 immediately; the next edge after release is processed normally.

Source files
------------

// File: rtl/syscall_unit_pkg.sv
// Shared constants, FSM state encoding and the register bundle for syscall_unit.
package syscall_unit_pkg;

   localparam int unsigned WORD_W     = 16;
   localparam int unsigned SYSREGS_W  = 48;
   localparam int unsigned TRIG_AW    = 10;
   localparam int unsigned TRIG_IDX_W = 17;
   localparam int unsigned TRIG_DEPTH = 720;
   localparam int unsigned STR_MAX    = 256;
   localparam int unsigned CNT_W      = 9;

   // sysregs = {b, a, code}
   localparam int unsigned CODE_LSB = 0;
   localparam int unsigned A_LSB    = 16;
   localparam int unsigned B_LSB    = 32;

   localparam logic [WORD_W-1:0] SYS_HALT    = 16'd0;
   localparam logic [WORD_W-1:0] SYS_STORE   = 16'd1;
   localparam logic [WORD_W-1:0] SYS_LOAD    = 16'd2;
   localparam logic [WORD_W-1:0] SYS_PUTNUM  = 16'd3;
   localparam logic [WORD_W-1:0] SYS_PUTCHAR = 16'd4;
   localparam logic [WORD_W-1:0] SYS_PUTSTR  = 16'd5;
   localparam logic [WORD_W-1:0] SYS_VACT    = 16'd6;
   localparam logic [WORD_W-1:0] SYS_VCLR    = 16'd7;
   localparam logic [WORD_W-1:0] SYS_VWRITE  = 16'd8;
   localparam logic [WORD_W-1:0] SYS_SIN     = 16'd9;
   localparam logic [WORD_W-1:0] SYS_COS     = 16'd10;

   typedef enum logic [2:0] {
      S_IDLE, S_MRD, S_TRD, S_EMIT, S_SRD, S_SEMIT, S_DONE
   } state_t;

   // Every flop of the unit: FSM bookkeeping plus all registered outputs.
   typedef struct packed {
      state_t              state;
      logic                phase;
      logic                trig_oor;
      logic [CNT_W-1:0]    cnt;
      logic                busy;
      logic                halted;
      logic                load_signal;
      logic [WORD_W-1:0]   load_data;
      logic [WORD_W-1:0]   mem_addr;
      logic [WORD_W-1:0]   mem_wdata;
      logic                mem_we;
      logic                mem_re;
      logic [TRIG_AW-1:0]  trig_addr;
      logic                trig_re;
      logic                video_activate;
      logic                video_clear;
      logic                video_write;
      logic [WORD_W-1:0]   video_addr;
      logic [WORD_W-1:0]   video_data;
      logic                out_valid;
      logic                out_is_num;
      logic [WORD_W-1:0]   out_data;
   } regs_t;

   // Codes whose result is delivered through load_data/load_signal.
   function automatic logic is_load_code(input logic [WORD_W-1:0] code);
      return (code == SYS_LOAD) || (code == SYS_SIN) || (code == SYS_COS);
   endfunction

endpackage

// File: rtl/syscall_unit_if.sv
// Bus bundle between the syscall unit (master) and cpu/memory/trig/vga/text side (slave).
interface syscall_unit_if;
   import syscall_unit_pkg::*;

   logic                 sys_signal;
   logic [SYSREGS_W-1:0] sysregs;
   logic                 busy;
   logic                 halted;
   logic                 load_signal;
   logic [WORD_W-1:0]    load_data;
   logic [WORD_W-1:0]    mem_addr;
   logic [WORD_W-1:0]    mem_wdata;
   logic                 mem_we;
   logic                 mem_re;
   logic [WORD_W-1:0]    mem_rdata;
   logic [TRIG_AW-1:0]   trig_addr;
   logic                 trig_re;
   logic [WORD_W-1:0]    trig_rdata;
   logic                 video_activate;
   logic                 video_clear;
   logic                 video_write;
   logic [WORD_W-1:0]    video_addr;
   logic [WORD_W-1:0]    video_data;
   logic                 out_valid;
   logic                 out_is_num;
   logic [WORD_W-1:0]    out_data;
   logic                 out_ready;

   modport master (
      input  sys_signal, sysregs, mem_rdata, trig_rdata, out_ready,
      output busy, halted, load_signal, load_data,
      output mem_addr, mem_wdata, mem_we, mem_re, trig_addr, trig_re,
      output video_activate, video_clear, video_write, video_addr, video_data,
      output out_valid, out_is_num, out_data
   );

   modport slave (
      output sys_signal, sysregs, mem_rdata, trig_rdata, out_ready,
      input  busy, halted, load_signal, load_data,
      input  mem_addr, mem_wdata, mem_we, mem_re, trig_addr, trig_re,
      input  video_activate, video_clear, video_write, video_addr, video_data,
      input  out_valid, out_is_num, out_data
   );

endinterface

// File: rtl/syscall_unit_edge_detect.sv
// Rising-edge detector on the syscall request level.
module syscall_edge_detect (
   input  logic clk,
   input  logic clear,
   input  logic sig,
   output logic rise_c
);

   logic prev_q, prev_d;

   // Previous level follows the input every cycle.
   always_comb prev_d = sig;

   // Previous-level register, cleared so a level high at release counts as an edge.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) prev_q <= 1'b0;
      else       prev_q <= prev_d;
   end

   assign rise_c = sig & ~prev_q;

endmodule

// File: rtl/syscall_unit.sv
// Syscall sequencer: decodes sysregs and drives memory, trig, vga and text output.
module syscall_unit
   import syscall_unit_pkg::*;
(
   input logic            clk,
   input logic            clear,
   syscall_unit_if.master bus
);

   regs_t                  r_q, r_d;
   logic                   sys_rise_c;
   logic [WORD_W-1:0]      code_c, arg_a_c, arg_b_c;
   logic [TRIG_IDX_W-1:0]  trig_idx_c;
   logic                   trig_oor_c;

   syscall_edge_detect u_edge (
      .clk    (clk),
      .clear  (clear),
      .sig    (bus.sys_signal),
      .rise_c (sys_rise_c)
   );

   // Field decode and 17-bit trig index (no wrap on 2a+1).
   always_comb begin
      code_c     = bus.sysregs[CODE_LSB +: WORD_W];
      arg_a_c    = bus.sysregs[A_LSB +: WORD_W];
      arg_b_c    = bus.sysregs[B_LSB +: WORD_W];
      trig_idx_c = {arg_a_c, 1'b0} + TRIG_IDX_W'(code_c == SYS_COS);
      trig_oor_c = trig_idx_c >= TRIG_IDX_W'(TRIG_DEPTH);
   end

   // Next-state and output logic; strobes default low so they last one cycle.
   always_comb begin
      r_d                = r_q;
      r_d.mem_we         = 1'b0;
      r_d.mem_re         = 1'b0;
      r_d.trig_re        = 1'b0;
      r_d.video_activate = 1'b0;
      r_d.video_clear    = 1'b0;
      r_d.video_write    = 1'b0;
      case (r_q.state)
         S_IDLE: begin
            if (sys_rise_c && !r_q.halted) begin
               r_d.busy  = 1'b1;
               r_d.phase = 1'b0;
               r_d.state = S_DONE;
               if (!is_load_code(code_c)) r_d.load_signal = 1'b0;
               case (code_c)
                  SYS_HALT:  r_d.halted = 1'b1;
                  SYS_STORE: begin
                     r_d.mem_we    = 1'b1;
                     r_d.mem_addr  = arg_a_c;
                     r_d.mem_wdata = arg_b_c;
                  end
                  SYS_LOAD: begin
                     r_d.mem_re   = 1'b1;
                     r_d.mem_addr = arg_a_c;
                     r_d.state    = S_MRD;
                  end
                  SYS_PUTNUM: begin
                     r_d.out_valid  = 1'b1;
                     r_d.out_is_num = 1'b1;
                     r_d.out_data   = arg_a_c;
                     r_d.state      = S_EMIT;
                  end
                  SYS_PUTCHAR: begin
                     r_d.out_valid  = 1'b1;
                     r_d.out_is_num = 1'b0;
                     r_d.out_data   = {8'h00, arg_a_c[7:0]};
                     r_d.state      = S_EMIT;
                  end
                  SYS_PUTSTR: begin
                     r_d.mem_re   = 1'b1;
                     r_d.mem_addr = arg_a_c;
                     r_d.cnt      = '0;
                     r_d.state    = S_SRD;
                  end
                  SYS_VACT: r_d.video_activate = 1'b1;
                  SYS_VCLR: r_d.video_clear    = 1'b1;
                  SYS_VWRITE: begin
                     r_d.video_write = 1'b1;
                     r_d.video_addr  = arg_a_c;
                     r_d.video_data  = arg_b_c;
                  end
                  SYS_SIN, SYS_COS: begin
                     r_d.trig_oor = trig_oor_c;
                     r_d.trig_re  = !trig_oor_c;
                     if (!trig_oor_c) r_d.trig_addr = TRIG_AW'(trig_idx_c);
                     r_d.state    = S_TRD;
                  end
                  default: ;
               endcase
            end
         end
         // phase 0: strobe cycle; phase 1: read data is valid
         S_MRD: begin
            if (!r_q.phase) r_d.phase = 1'b1;
            else begin
               r_d.load_data   = bus.mem_rdata;
               r_d.load_signal = 1'b1;
               r_d.state       = S_DONE;
            end
         end
         S_TRD: begin
            if (!r_q.phase) r_d.phase = 1'b1;
            else begin
               r_d.load_data   = r_q.trig_oor ? '0 : bus.trig_rdata;
               r_d.load_signal = 1'b1;
               r_d.state       = S_DONE;
            end
         end
         S_EMIT: begin
            if (bus.out_ready) begin
               r_d.out_valid = 1'b0;
               r_d.state     = S_DONE;
            end
         end
         S_SRD: begin
            if (!r_q.phase) r_d.phase = 1'b1;
            else if (bus.mem_rdata == '0) r_d.state = S_DONE;
            else begin
               r_d.out_valid  = 1'b1;
               r_d.out_is_num = 1'b0;
               r_d.out_data   = {8'h00, bus.mem_rdata[7:0]};
               r_d.state      = S_SEMIT;
            end
         end
         S_SEMIT: begin
            if (bus.out_ready) begin
               r_d.out_valid = 1'b0;
               r_d.cnt       = r_q.cnt + CNT_W'(1);
               if ((r_q.cnt + CNT_W'(1)) == CNT_W'(STR_MAX)) r_d.state = S_DONE;
               else begin
                  r_d.mem_re   = 1'b1;
                  r_d.mem_addr = r_q.mem_addr + WORD_W'(1);
                  r_d.phase    = 1'b0;
                  r_d.state    = S_SRD;
               end
            end
         end
         S_DONE: begin
            r_d.busy  = 1'b0;
            r_d.state = S_IDLE;
         end
         default: r_d.state = S_IDLE;
      endcase
   end

   // State and output registers; clear aborts any syscall in flight.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) r_q <= '0;
      else       r_q <= r_d;
   end

   assign bus.busy           = r_q.busy;
   assign bus.halted         = r_q.halted;
   assign bus.load_signal    = r_q.load_signal;
   assign bus.load_data      = r_q.load_data;
   assign bus.mem_addr       = r_q.mem_addr;
   assign bus.mem_wdata      = r_q.mem_wdata;
   assign bus.mem_we         = r_q.mem_we;
   assign bus.mem_re         = r_q.mem_re;
   assign bus.trig_addr      = r_q.trig_addr;
   assign bus.trig_re        = r_q.trig_re;
   assign bus.video_activate = r_q.video_activate;
   assign bus.video_clear    = r_q.video_clear;
   assign bus.video_write    = r_q.video_write;
   assign bus.video_addr     = r_q.video_addr;
   assign bus.video_data     = r_q.video_data;
   assign bus.out_valid      = r_q.out_valid;
   assign bus.out_is_num     = r_q.out_is_num;
   assign bus.out_data       = r_q.out_data;

endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: memory/trig responders, monitors and a syscall-level reference model.
module tb_syscall_unit;

   localparam int unsigned T_DEPTH = 720;
   localparam int unsigned S_MAX   = 256;

   logic clk = 1'b0;
   logic clear;

   syscall_unit_if bus ();

   syscall_unit dut (
      .clk   (clk),
      .clear (clear),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];

   int n_we = 0, n_re = 0, n_tre = 0, n_vact = 0, n_vclr = 0, n_vwr = 0;
   int n_overlap = 0, n_unstable = 0, strobes;
   logic [15:0] last_we_addr, last_we_data;
   logic [9:0]  last_tre_addr;
   logic        pend = 1'b0;
   logic [15:0] pend_data;
   logic [16:0] got_q [$];

   int exp_we = 0, exp_re = 0, exp_tre = 0, exp_vact = 0, exp_vclr = 0, exp_vwr = 0;
   logic        exp_halted = 1'b0, exp_ls = 1'b0;
   logic [15:0] exp_ld = '0, exp_va = '0, exp_vd = '0;
   logic [16:0] exp_q [$];

   function automatic logic [15:0] trig_fn(input int unsigned i);
      return 16'(i * 97 + 32'h1357);
   endfunction

   // Memory and trig table responders: read data valid the cycle after the strobe.
   always @(posedge clk) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
      if (bus.trig_re) bus.trig_rdata <= trig_fn(32'(bus.trig_addr));
   end

   // Strobe counters, overlap and output-hold monitor, item capture.
   always @(posedge clk) begin
      strobes = 32'(bus.mem_we) + 32'(bus.mem_re) + 32'(bus.trig_re) +
                32'(bus.video_activate) + 32'(bus.video_clear) + 32'(bus.video_write);
      if (strobes > 1) n_overlap++;
      if (bus.mem_we) begin n_we++; last_we_addr = bus.mem_addr; last_we_data = bus.mem_wdata; end
      if (bus.mem_re) n_re++;
      if (bus.trig_re) begin n_tre++; last_tre_addr = bus.trig_addr; end
      if (bus.video_activate) n_vact++;
      if (bus.video_clear) n_vclr++;
      if (bus.video_write) n_vwr++;
      if (clear) pend = 1'b0;
      else begin
         if (pend && (!bus.out_valid || bus.out_data !== pend_data)) n_unstable++;
         if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_is_num, bus.out_data});
         pend      = bus.out_valid && !bus.out_ready;
         pend_data = bus.out_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic put_mem(input logic [15:0] addr, input logic [15:0] val);
      mem[addr]     = val;
      ref_mem[addr] = val;
   endtask

   // Syscall-level reference: what a completed syscall leaves behind.
   task automatic model_call(input logic [15:0] code, input logic [15:0] a, input logic [15:0] b);
      int unsigned idx;
      logic [15:0] w;
      if (exp_halted) return;
      if (!(code == 16'd2 || code == 16'd9 || code == 16'd10)) exp_ls = 1'b0;
      case (code)
         16'd0: exp_halted = 1'b1;
         16'd1: begin ref_mem[a] = b; exp_we++; end
         16'd2: begin exp_re++; exp_ld = ref_mem[a]; exp_ls = 1'b1; end
         16'd3: exp_q.push_back({1'b1, a});
         16'd4: exp_q.push_back({1'b0, 8'h00, a[7:0]});
         16'd5: begin
            for (int i = 0; i < int'(S_MAX); i++) begin
               w = ref_mem[a + 16'(i)];
               exp_re++;
               if (w == 16'h0) break;
               exp_q.push_back({1'b0, 8'h00, w[7:0]});
            end
         end
         16'd6: exp_vact++;
         16'd7: exp_vclr++;
         16'd8: begin exp_vwr++; exp_va = a; exp_vd = b; end
         16'd9, 16'd10: begin
            idx = 32'(a) * 2 + ((code == 16'd10) ? 32'd1 : 32'd0);
            if (idx < T_DEPTH) begin exp_tre++; exp_ld = trig_fn(idx); end
            else exp_ld = 16'h0;
            exp_ls = 1'b1;
         end
         default: ;
      endcase
   endtask

   task automatic chk_all(input string tag);
      chk({tag, " busy"}, 32'(bus.busy), 32'd0);
      chk({tag, " halted"}, 32'(bus.halted), 32'(exp_halted));
      chk({tag, " load_signal"}, 32'(bus.load_signal), 32'(exp_ls));
      chk({tag, " load_data"}, 32'(bus.load_data), 32'(exp_ld));
      chk({tag, " video_addr"}, 32'(bus.video_addr), 32'(exp_va));
      chk({tag, " video_data"}, 32'(bus.video_data), 32'(exp_vd));
      chk({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, " n_mem_we"}, 32'(n_we), 32'(exp_we));
      chk({tag, " n_mem_re"}, 32'(n_re), 32'(exp_re));
      chk({tag, " n_trig_re"}, 32'(n_tre), 32'(exp_tre));
      chk({tag, " n_vact"}, 32'(n_vact), 32'(exp_vact));
      chk({tag, " n_vclr"}, 32'(n_vclr), 32'(exp_vclr));
      chk({tag, " n_vwrite"}, 32'(n_vwr), 32'(exp_vwr));
      chk({tag, " overlap"}, 32'(n_overlap), 32'd0);
      chk({tag, " hold"}, 32'(n_unstable), 32'd0);
      chk({tag, " n_items"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s item%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic wait_idle(input string tag, input bit rnd);
      bit ok = 1'b0;
      for (int k = 0; k < 4000; k++) begin
         if (!bus.busy) begin ok = 1'b1; break; end
         @(negedge clk);
         bus.out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      chk({tag, " idle_timeout"}, 32'(ok), 32'd1);
   endtask

   task automatic wait_valid(input string tag);
      bit ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (bus.out_valid) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk({tag, " valid_timeout"}, 32'(ok), 32'd1);
   endtask

   task automatic do_call(input logic [15:0] code, input logic [15:0] a, input logic [15:0] b,
                          input bit rnd);
      string tag;
      bit    acc;
      tag = $sformatf("code%0h a%0h", code, a);
      acc = !exp_halted;
      model_call(code, a, b);
      @(negedge clk);
      bus.sysregs    = {b, a, code};
      bus.sys_signal = 1'b1;
      bus.out_ready  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      chk({tag, " accept_busy"}, 32'(bus.busy), 32'(acc));
      bus.sys_signal = 1'b0;
      wait_idle(tag, rnd);
      chk_all(tag);
   endtask

   initial begin
      logic [15:0] rc, ra, rb;
      int          sel, len;

      for (int i = 0; i < 65536; i++) begin mem[i] = '0; ref_mem[i] = '0; end
      clear          = 1'b1;
      bus.sys_signal = 1'b0;
      bus.sysregs    = '0;
      bus.out_ready  = 1'b0;
      repeat (3) @(negedge clk);

      chk("rst busy", 32'(bus.busy), 32'd0);
      chk("rst halted", 32'(bus.halted), 32'd0);
      chk("rst load_signal", 32'(bus.load_signal), 32'd0);
      chk("rst strobes", 32'({bus.mem_we, bus.mem_re, bus.trig_re, bus.video_write}), 32'd0);
      chk("rst out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst mem_addr", 32'(bus.mem_addr), 32'd0);
      clear = 1'b0;

      // store then load with exact latency
      do_call(16'd1, 16'h0100, 16'hBEEF, 1'b0);
      chk("store addr", 32'(last_we_addr), 32'h0100);
      chk("store data", 32'(last_we_data), 32'hBEEF);
      model_call(16'd2, 16'h0100, 16'h0);
      @(negedge clk);
      bus.sysregs = {16'h0, 16'h0100, 16'd2}; bus.sys_signal = 1'b1;
      @(negedge clk);
      chk("load busy", 32'(bus.busy), 32'd1);
      chk("load ls t1", 32'(bus.load_signal), 32'd0);
      bus.sys_signal = 1'b0;
      @(negedge clk);
      chk("load ls t2", 32'(bus.load_signal), 32'd0);
      @(negedge clk);
      chk("load ls t3", 32'(bus.load_signal), 32'd1);
      chk("load data t3", 32'(bus.load_data), 32'hBEEF);
      wait_idle("load", 1'b0);
      chk_all("load");

      // "Hi" with backpressure on 'i'
      put_mem(16'h0200, 16'h0048); put_mem(16'h0201, 16'h0069); put_mem(16'h0202, 16'h0000);
      model_call(16'd5, 16'h0200, 16'h0);
      @(negedge clk);
      bus.sysregs = {16'h0, 16'h0200, 16'd5}; bus.sys_signal = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.sys_signal = 1'b0;
      wait_valid("Hi H");
      chk("Hi H data", 32'(bus.out_data), 32'h48);
      chk("Hi H is_num", 32'(bus.out_is_num), 32'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      wait_valid("Hi i");
      chk("Hi i data", 32'(bus.out_data), 32'h69);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("Hi i held%0d", k), 32'({bus.out_valid, bus.out_data}), 32'h10069);
      end
      bus.out_ready = 1'b1;
      wait_idle("Hi", 1'b0);
      chk_all("Hi");

      // trig indices and range boundary
      do_call(16'd9, 16'd10, 16'h0, 1'b0);
      chk("sin10 trig_addr", 32'(last_tre_addr), 32'd20);
      do_call(16'd10, 16'd10, 16'h0, 1'b0);
      chk("cos10 trig_addr", 32'(last_tre_addr), 32'd21);
      do_call(16'd9, 16'd400, 16'h0, 1'b0);
      do_call(16'd10, 16'd359, 16'h0, 1'b0);
      chk("cos359 trig_addr", 32'(last_tre_addr), 32'd719);
      do_call(16'd9, 16'd360, 16'h0, 1'b0);
      do_call(16'd10, 16'hFFFF, 16'h0, 1'b0);

      // video write, activate, clear, and an unknown code
      do_call(16'd8, 16'd5, 16'h0041, 1'b0);
      do_call(16'd6, 16'h0, 16'h0, 1'b0);
      do_call(16'd7, 16'h0, 16'h0, 1'b0);
      do_call(16'h0042, 16'h1234, 16'h5678, 1'b0);

      // address wrap and STR_MAX termination
      put_mem(16'hFFFE, 16'h0041); put_mem(16'hFFFF, 16'h0042);
      put_mem(16'h0000, 16'h0043); put_mem(16'h0001, 16'h0000);
      do_call(16'd5, 16'hFFFE, 16'h0, 1'b1);
      for (int j = 0; j < 300; j++) put_mem(16'h3000 + 16'(j), 16'h0100 + 16'(j));
      do_call(16'd5, 16'h3000, 16'h0, 1'b0);

      // randomized syscalls against the model
      for (int it = 0; it < 60; it++) begin
         sel = $urandom_range(0, 10);
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         case (sel)
            0: begin rc = 16'd1; ra = 16'h0100 + 16'($urandom_range(0, 7)); end
            1: begin rc = 16'd2; ra = 16'h0100 + 16'($urandom_range(0, 7)); end
            2: rc = 16'd3;
            3: rc = 16'd4;
            4: begin
               rc  = 16'd5;
               ra  = 16'h1000 + 16'($urandom_range(0, 255) * 16);
               len = $urandom_range(0, 5);
               for (int j = 0; j < len; j++) put_mem(ra + 16'(j), 16'($urandom_range(1, 65535)));
               put_mem(ra + 16'(len), 16'h0);
            end
            5: rc = 16'd6;
            6: rc = 16'd7;
            7: rc = 16'd8;
            8: begin rc = 16'd9;  ra = 16'($urandom_range(0, 400)); end
            9: begin rc = 16'd10; ra = 16'($urandom_range(0, 400)); end
            default: rc = 16'($urandom_range(11, 65535));
         endcase
         do_call(rc, ra, rb, 1'b1);
      end

      // request edge while busy is dropped
      put_mem(16'h0400, 16'h0078); put_mem(16'h0401, 16'h0079); put_mem(16'h0402, 16'h0000);
      model_call(16'd5, 16'h0400, 16'h0);
      @(negedge clk);
      bus.sysregs = {16'h0, 16'h0400, 16'd5}; bus.sys_signal = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.sys_signal = 1'b0;
      wait_valid("drop");
      @(negedge clk);
      bus.sysregs = {16'h1234, 16'h0500, 16'd1}; bus.sys_signal = 1'b1;
      @(negedge clk);
      bus.sys_signal = 1'b0;
      @(negedge clk);
      bus.out_ready = 1'b1;
      wait_idle("drop", 1'b0);
      chk_all("drop");
      chk("drop mem500", 32'(mem[16'h0500]), 32'(ref_mem[16'h0500]));

      // clear during SEMIT, then a request held across release
      put_mem(16'h0600, 16'h0070); put_mem(16'h0601, 16'h0071); put_mem(16'h0602, 16'h0000);
      exp_re++;
      @(negedge clk);
      bus.sysregs = {16'h0, 16'h0600, 16'd5}; bus.sys_signal = 1'b1; bus.out_ready = 1'b0;
      @(negedge clk);
      bus.sys_signal = 1'b0;
      wait_valid("clr");
      chk("clr pre data", 32'(bus.out_data), 32'h70);
      @(negedge clk);
      clear = 1'b1;
      #1;
      chk("clr busy", 32'(bus.busy), 32'd0);
      chk("clr out", 32'({bus.out_valid, bus.out_data}), 32'd0);
      chk("clr mem_addr", 32'(bus.mem_addr), 32'd0);
      chk("clr video", 32'({bus.video_addr, bus.video_data}), 32'd0);
      chk("clr load", 32'({bus.load_signal, bus.load_data}), 32'd0);
      exp_ls = 1'b0; exp_ld = '0; exp_va = '0; exp_vd = '0; exp_halted = 1'b0;
      bus.sysregs = {16'h5555, 16'h0700, 16'd1}; bus.sys_signal = 1'b1;
      repeat (2) @(negedge clk);
      clear = 1'b0;
      model_call(16'd1, 16'h0700, 16'h5555);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("post-clear accept", 32'(bus.busy), 32'd1);
      bus.sys_signal = 1'b0;
      wait_idle("post-clear", 1'b0);
      chk_all("post-clear");
      do_call(16'd2, 16'h0700, 16'h0, 1'b0);

      // halt, then further requests ignored
      do_call(16'd0, 16'h0, 16'h0, 1'b0);
      chk("halted set", 32'(bus.halted), 32'd1);
      do_call(16'd1, 16'h0800, 16'h7777, 1'b0);
      do_call(16'd3, 16'h0001, 16'h0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
